cpu_mem_responder: RTL and testbench
====================================

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 pc_out  in  11  CPU instruction fetch address.
REQ-005 ram_w_en1  in  1  CPU port-1 write strobe; this block does not support port-1 writes.
REQ-006 ram_addr2, ram_w_en2, ram_in2  in  11/1/32  CPU data-port address, write enable and write data.
REQ-007 ld_start  in  1  single-cycle pulse that begins a program load.
REQ-008 ld_start_pc  in  11  start PC, captured on ld_start.
REQ-009 ld_valid, ld_data, ld_last  in  1/32/1  loader word stream; ld_last marks the final word.
REQ-010 instr  out  32  fetched instruction.
REQ-011 ram_data2  out  32  data-port read data.
REQ-012 start_pc  out  11  to CPU start_pc.
REQ-013 cpu_rst_n  out  1  CPU reset, active low.
REQ-014 ld_ready  out  1  loader handshake ready.
REQ-015 load_count  out  12  number of words accepted in the current load.
REQ-016 err_w1, ld_ovf  out  1/1  sticky error flags.

Function
REQ-017 Storage SHALL be 2048 x 32 words, addressed by 11-bit word address; contents SHALL NOT be reset.
REQ-018 FSM states SHALL be IDLE, LOAD and RUN.
REQ-019 IDLE SHALL drive cpu_rst_n=0 and ld_ready=0, and SHALL go to LOAD on ld_start.
REQ-020 On entering LOAD, the block SHALL clear the load address and load_count, capture ld_start_pc into start_pc, and clear ld_ovf.
REQ-021 In LOAD, the block SHALL drive ld_ready=1 and cpu_rst_n=0.
REQ-022 Each cycle with ld_valid&ld_ready SHALL write ld_data at the load address and increment both the load address and load_count.
REQ-023 An accepted word with ld_last=1 SHALL move the FSM to RUN on the next edge.
REQ-024 If the load address wraps from 2047 to 0 without ld_last, the block SHALL set ld_ovf, continue writing from address 0, and saturate load_count at 2048.
REQ-025 RUN SHALL drive cpu_rst_n=1 (registered, rising one cycle after the last accepted word) and ld_ready=0.
REQ-026 ld_start in RUN SHALL return the FSM to LOAD, with cpu_rst_n=0 on the next cycle.
REQ-027 ld_start in LOAD SHALL restart the load at address 0.
REQ-028 ld_valid outside LOAD SHALL be ignored.
REQ-029 Fetch in RUN: instr SHALL equal mem[pc_out sampled at edge N], valid after edge N (one-cycle latency); outside RUN, instr SHALL be 0.
REQ-030 Data port in RUN: ram_data2 SHALL equal mem[ram_addr2] with one-cycle latency.
REQ-031 When ram_w_en2=1 in RUN, the block SHALL write ram_in2 to mem[ram_addr2] at the edge.
REQ-032 A same-address data-port read during a write SHALL return the old contents (read-first).
REQ-033 Data-port writes outside RUN SHALL be ignored.
REQ-034 ram_w_en1=1 in RUN SHALL set err_w1 (sticky until reset) and SHALL NOT modify memory.
REQ-035 The loader write has priority; no other write occurs in LOAD, so there is no port conflict.

Reset
REQ-036 rst_n low SHALL immediately force state=IDLE, instr=0, ram_data2=0, start_pc=0, cpu_rst_n=0, ld_ready=0, load_count=0, err_w1=0 and ld_ovf=0.
REQ-037 Reset during LOAD SHALL abandon the load; words already written remain in memory.

Configuration
REQ-038 With macro CPU_MEM_BYPASS_EN defined: a fetch whose pc_out equals ram_addr2 while ram_w_en2=1 in the same cycle SHALL return ram_in2 on instr.
REQ-039 Without CPU_MEM_BYPASS_EN: that same fetch SHALL return the old memory word.
REQ-040 CPU_MEM_BYPASS_EN SHALL NOT affect the data port, which remains read-first.

Verification
REQ-041 Scenario 1: ld_start with ld_start_pc=5, then load 3 words (0xE3A00001, 0xE3A01002, 0xE0800001), last on word 3 -> load_count=3; start_pc=5; cpu_rst_n rises 1 cycle after the last word; pc_out=2 yields instr=0xE0800001 one cycle later.
REQ-042 Scenario 2: in RUN, write ram_addr2=100 with ram_in2=0xDEADBEEF, then read 100 -> ram_data2=0xDEADBEEF; a same-cycle read+write of 100 with 0x1 returns 0xDEADBEEF.
REQ-043 Scenario 3: stream 2049 words with no ld_last -> ld_ovf=1, load_count=2048, and mem[0] holds word 2049.
REQ-044 Scenario 4: assert rst_n=0 mid-load after 2 words -> all outputs reach reset values without a clock edge; state=IDLE.
REQ-045 Scenario 5: ram_w_en1=1 in RUN -> err_w1=1 and memory is unchanged; ld_start in RUN -> cpu_rst_n=0 next cycle.
REQ-046 Scenario 6: pc_out=ram_addr2=7 with ram_w_en2=1 and ram_in2=0x55 -> instr=0x55 with CPU_MEM_BYPASS_EN defined, old mem[7] without it.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// ----------------------------------------------------------------------------
// Program memory and loader for a small CPU. A loader streams 32-bit words
// into a 2048 x 32 memory while the CPU is held in reset. Once the final word
// has been accepted, the CPU is released. It then fetches instructions on one
// read port and uses a second, read-first data port.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   pc_out[10:0]                    CPU fetch address
//   ram_w_en1                       CPU port-1 write strobe (illegal, flagged)
//   ram_addr2/ram_w_en2/ram_in2     CPU data port address/write enable/data
//   ld_start, ld_start_pc[10:0]     begin a program load, CPU start address
//   ld_valid, ld_data[31:0], ld_last  loader word stream
//   instr[31:0]                     fetched instruction (0 unless running)
//   ram_data2[31:0]                 data-port read data
//   start_pc[10:0]                  start address handed to the CPU
//   cpu_rst_n                       CPU reset, low while idle or loading
//   ld_ready                        loader handshake ready
//   load_count[11:0]                words accepted in this load (max 2048)
//   err_w1, ld_ovf                  sticky error flags
//
// Configuration
//   CPU_MEM_BYPASS_EN  when defined, a fetch from the address that the data
//                      port is writing in the same cycle returns the new data.
// ----------------------------------------------------------------------------
module cpu_mem_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pc_out,
  input  logic        ram_w_en1,
  input  logic [10:0] ram_addr2,
  input  logic        ram_w_en2,
  input  logic [31:0] ram_in2,
  input  logic        ld_start,
  input  logic [10:0] ld_start_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic [31:0] instr,
  output logic [31:0] ram_data2,
  output logic [10:0] start_pc,
  output logic        cpu_rst_n,
  output logic        ld_ready,
  output logic [11:0] load_count,
  output logic        err_w1,
  output logic        ld_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [11:0] COUNT_MAX = 12'd2048;

  state_t      state;
  state_t      next_state;
  logic [10:0] load_addr;
  logic [31:0] instr_q;
  logic        accept;
  logic        fetch_bypass;

  logic [31:0] mem [0:2047];

  // A word is taken only while loading. A cycle that restarts the load
  // refuses the word rather than dropping a handshaken word.
  assign ld_ready = (state == LOAD) && !ld_start;
  assign accept   = ld_ready && ld_valid;

  // Same-cycle fetch of the address that the data port is writing.
`ifdef CPU_MEM_BYPASS_EN
  assign fetch_bypass = ram_w_en2 && (pc_out == ram_addr2);
`else
  assign fetch_bypass = 1'b0;
`endif

  // The fetch register can hold a stale word for one cycle after RUN ends,
  // so the output is gated to guarantee 0 outside RUN.
  assign instr = (state == RUN) ? instr_q : 32'd0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. ld_start always (re)starts a load, whatever the state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ld_start) next_state = LOAD;
      end
      LOAD: begin
        if (ld_start)              next_state = LOAD;
        else if (accept && ld_last) next_state = RUN;
      end
      RUN: begin
        if (ld_start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Loader bookkeeping. The address wraps naturally at 11 bits. The count
  // saturates, so an overrun load still reports a full memory. Overflow is
  // flagged when the word at the top address is not the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_addr  <= '0;
      load_count <= '0;
      start_pc   <= '0;
      ld_ovf     <= 1'b0;
    end else if (ld_start) begin
      load_addr  <= '0;
      load_count <= '0;
      start_pc   <= ld_start_pc;
      ld_ovf     <= 1'b0;
    end else if (accept) begin
      load_addr <= load_addr + 11'd1;
      if (load_count != COUNT_MAX) load_count <= load_count + 12'd1;
      if ((load_addr == 11'h7FF) && !ld_last) ld_ovf <= 1'b1;
    end
  end

  // CPU reset tracks the registered state. It rises on the edge that
  // accepts the last word and falls on the edge that samples ld_start.
  // Port-1 writes are not supported. Any attempt while running is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      err_w1    <= 1'b0;
    end else begin
      cpu_rst_n <= (next_state == RUN);
      if ((state == RUN) && ram_w_en1) err_w1 <= 1'b1;
    end
  end

  // Single memory write port. In LOAD only the loader writes, and in RUN only
  // the data port writes, so the two never collide. Contents are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[load_addr] <= ld_data;
    end else if ((state == RUN) && ram_w_en2) begin
      mem[ram_addr2] <= ram_in2;
    end
  end

  // Registered reads. Because the write above is non-blocking, a read of the
  // address being written in the same cycle sees the old word (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      ram_data2 <= '0;
    end else if (state == RUN) begin
      instr_q   <= fetch_bypass ? ram_in2 : mem[pc_out];
      ram_data2 <= mem[ram_addr2];
    end else begin
      instr_q   <= '0;
      ram_data2 <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for cpu_mem_responder. Stimulus tasks update a
// behavioural memory model, then queue the expected DUT outputs tagged with
// the cycle in which they must appear. An independent monitor checks every
// queued expectation on the falling edge of that cycle.
// ----------------------------------------------------------------------------
module tb_cpu_mem_responder;

  localparam int S_INSTR = 0;
  localparam int S_DATA2 = 1;
  localparam int S_SPC   = 2;
  localparam int S_CRST  = 3;
  localparam int S_RDY   = 4;
  localparam int S_CNT   = 5;
  localparam int S_ERR   = 6;
  localparam int S_OVF   = 7;

  logic        clk;
  logic        rst_n;
  logic [10:0] pc_out;
  logic        ram_w_en1;
  logic [10:0] ram_addr2;
  logic        ram_w_en2;
  logic [31:0] ram_in2;
  logic        ld_start;
  logic [10:0] ld_start_pc;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [31:0] instr;
  logic [31:0] ram_data2;
  logic [10:0] start_pc;
  logic        cpu_rst_n;
  logic        ld_ready;
  logic [11:0] load_count;
  logic        err_w1;
  logic        ld_ovf;

  cpu_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_out     (pc_out),
    .ram_w_en1  (ram_w_en1),
    .ram_addr2  (ram_addr2),
    .ram_w_en2  (ram_w_en2),
    .ram_in2    (ram_in2),
    .ld_start   (ld_start),
    .ld_start_pc(ld_start_pc),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .instr      (instr),
    .ram_data2  (ram_data2),
    .start_pc   (start_pc),
    .cpu_rst_n  (cpu_rst_n),
    .ld_ready   (ld_ready),
    .load_count (load_count),
    .err_w1     (err_w1),
    .ld_ovf     (ld_ovf)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: memory contents, which addresses hold defined data,
  // and the loader/flag state derived from the rules.
  logic [31:0] model_mem [2048];
  bit          known [2048];
  int          load_idx = 0;
  int          model_count = 0;
  bit          model_ovf = 0;
  bit          model_err = 0;

  // Free-running clock with a cycle counter that advances on each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_INSTR: return instr;
      S_DATA2: return ram_data2;
      S_SPC:   return {21'd0, start_pc};
      S_CRST:  return {31'd0, cpu_rst_n};
      S_RDY:   return {31'd0, ld_ready};
      S_CNT:   return {20'd0, load_count};
      S_ERR:   return {31'd0, err_w1};
      default: return {31'd0, ld_ovf};
    endcase
  endfunction

  function automatic void compare(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  // Queue an expectation for lat cycles from now, keeping the queue sorted.
  function automatic void checkOutput(input string name, input int sel,
                                      input logic [31:0] exp, input int lat);
    exp_t e;
    int   i;
    e.due  = cyc + lat;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endfunction

  // Monitor: checks every expectation that falls due in this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      compare(e.name, get_sig(e.sel), e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 20) begin
      tick();
      g++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values();
    compare("rst_instr",      instr,                 32'd0);
    compare("rst_ram_data2",  ram_data2,             32'd0);
    compare("rst_start_pc",   {21'd0, start_pc},     32'd0);
    compare("rst_cpu_rst_n",  {31'd0, cpu_rst_n},    32'd0);
    compare("rst_ld_ready",   {31'd0, ld_ready},     32'd0);
    compare("rst_load_count", {20'd0, load_count},   32'd0);
    compare("rst_err_w1",     {31'd0, err_w1},       32'd0);
    compare("rst_ld_ovf",     {31'd0, ld_ovf},       32'd0);
  endtask

  task automatic idle_inputs();
    ram_w_en1 = 1'b0;
    ram_w_en2 = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
  endtask

  // Begin (or restart) a load; the CPU is in reset from the next cycle on.
  task automatic start_load(input logic [10:0] pc);
    idle_inputs();
    ld_start    = 1'b1;
    ld_start_pc = pc;
    load_idx    = 0;
    model_count = 0;
    model_ovf   = 0;
    checkOutput("load_start_pc",  S_SPC,   {21'd0, pc}, 1);
    checkOutput("load_count_clr", S_CNT,   32'd0, 1);
    checkOutput("load_ready",     S_RDY,   32'd1, 1);
    checkOutput("load_cpu_rst_n", S_CRST,  32'd0, 1);
    checkOutput("load_ovf_clr",   S_OVF,   32'd0, 1);
    checkOutput("load_instr_0",   S_INSTR, 32'd0, 1);
    tick();
    ld_start = 1'b0;
  endtask

  // Present one loader word; it is accepted at the next edge.
  task automatic send_word(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    model_mem[load_idx] = data;
    known[load_idx]     = 1'b1;
    if (!last && load_idx == 2047) model_ovf = 1;
    load_idx = (load_idx + 1) % 2048;
    if (model_count < 2048) model_count++;
    checkOutput("word_count", S_CNT, model_count, 1);
    checkOutput("word_ovf",   S_OVF, {31'd0, model_ovf}, 1);
    if (last) begin
      checkOutput("last_cpu_rst_n_low", S_CRST, 32'd0, 0);
      checkOutput("run_cpu_rst_n",      S_CRST, 32'd1, 1);
      checkOutput("run_ld_ready",       S_RDY,  32'd0, 1);
    end
    tick();
    if (last) begin
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
  endtask

  // One CPU cycle in RUN: fetch, data-port access, optional port-1 write
  // and optional stray loader word.
  task automatic applyStimulus(input logic [10:0] pc, input logic [10:0] a2,
                               input logic we2, input logic [31:0] d2,
                               input logic we1, input logic lv);
    bit hit;
    pc_out    = pc;
    ram_addr2 = a2;
    ram_w_en2 = we2;
    ram_in2   = d2;
    ram_w_en1 = we1;
    ld_valid  = lv;
    ld_data   = $urandom;
    ld_last   = lv & 1'($urandom_range(0, 1));
    hit = we2 && (pc == a2);
`ifdef CPU_MEM_BYPASS_EN
    if (hit)           checkOutput("instr_bypass", S_INSTR, d2, 1);
    else if (known[pc]) checkOutput("instr", S_INSTR, model_mem[pc], 1);
`else
    if (known[pc]) checkOutput(hit ? "instr_old" : "instr", S_INSTR, model_mem[pc], 1);
`endif
    if (known[a2]) checkOutput("ram_data2", S_DATA2, model_mem[a2], 1);
    if (we2) begin
      model_mem[a2] = d2;
      known[a2]     = 1'b1;
    end
    if (we1) model_err = 1;
    checkOutput("err_w1",     S_ERR,  {31'd0, model_err}, 1);
    checkOutput("run_count",  S_CNT,  model_count, 1);
    checkOutput("run_cpu_on", S_CRST, 32'd1, 1);
    tick();
    idle_inputs();
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'hE3A00001;
    prog[1] = 32'hE3A01002;
    prog[2] = 32'hE0800001;
    for (int i = 0; i < 2048; i++) known[i] = 1'b0;
    rst_n       = 1'b0;
    pc_out      = '0;
    ram_addr2   = '0;
    ram_in2     = '0;
    ld_start_pc = '0;
    ld_data     = '0;
    idle_inputs();

    // Reset state
    tick();
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_ready",     S_RDY,  32'd0, 0);
    checkOutput("idle_cpu_rst_n", S_CRST, 32'd0, 0);
    tick();

    // Scenario 1: three-word program, start_pc 5, fetch from PC 2
    $display("[TB] program load");
    start_load(11'd5);
    for (int i = 0; i < 3; i++) send_word(prog[i], i == 2);
    applyStimulus(11'd2, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(11'd0, 11'd1, 1'b0, 32'd0, 1'b0, 1'b0);

    // Scenario 2: data port write, read back, read-first collision
    $display("[TB] data port");
    applyStimulus(11'd0, 11'd100, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(11'd1, 11'd100, 1'b0, 32'd0,        1'b0, 1'b0);
    applyStimulus(11'd2, 11'd100, 1'b1, 32'h00000001, 1'b0, 1'b0);
    applyStimulus(11'd100, 11'd100, 1'b0, 32'd0,      1'b0, 1'b0);

    // Scenario 5: illegal port-1 write, then reload from RUN
    $display("[TB] port-1 write and reload");
    applyStimulus(11'd1, 11'd2, 1'b0, 32'h12345678, 1'b1, 1'b1);
    applyStimulus(11'd1, 11'd2, 1'b0, 32'h0,        1'b0, 1'b0);
    start_load(11'd3);
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
    start_load(11'd7);
    for (int i = 0; i < 16; i++) send_word($urandom, i == 15);

    // Randomized RUN traffic over a small address window
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(11'($urandom_range(0, 31)), 11'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
    end

    // Scenario 6: fetch and write of address 7 in the same cycle
    applyStimulus(11'd7, 11'd7, 1'b1, 32'h00000055, 1'b0, 1'b0);
    applyStimulus(11'd7, 11'd7, 1'b0, 32'h0,        1'b0, 1'b0);

    // Scenario 3: overrun load of 2049 words, then finish with a last word
    $display("[TB] overflow load");
    start_load(11'd0);
    for (int i = 0; i < 2049; i++) send_word($urandom, 1'b0);
    send_word(32'hA5A5_0001, 1'b1);
    applyStimulus(11'd0, 11'd1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(11'd2047, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Scenario 4: asynchronous reset two words into a load
    $display("[TB] reset mid-load");
    start_load(11'd9);
    send_word(32'h1111_0000, 1'b0);
    send_word(32'h2222_0001, 1'b0);
    ld_valid = 1'b0;
    drain();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_err   = 0;
    model_ovf   = 0;
    model_count = 0;
    tick();
    rst_n = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    ld_valid = 1'b0;
    checkOutput("idle_ignores_valid", S_CNT,  32'd0, 0);
    checkOutput("idle_cpu_rst_n2",    S_CRST, 32'd0, 0);
    tick();
    start_load(11'd9);
    send_word(32'h3333_0000, 1'b1);
    applyStimulus(11'd1, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(11'd0, 11'd1, 1'b0, 32'd0, 1'b0, 1'b0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
